int_divider: RTL and testbench

- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits in the execute stage beside the single-cycle alu; the hazard unit stalls the pipeline while busy_o is high.
- Accepts one operation per request and returns one result, with a one-cycle valid pulse, after a fixed latency or an early special-case exit.

---
 rtl/int_divider_pkg.sv | 23 ++
 rtl/int_divider_if.sv | 24 ++
 rtl/int_divider_operand_prep.sv | 52 +++++
 rtl/int_divider.sv | 155 +++++++++++++++
 tb/tb_int_divider.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_divider_pkg.sv
// Shared types and constants for the RV32M iterative divider.
// Optional feature macro used elsewhere: INT_DIVIDER_EARLY_OUT_EN.
package int_div_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/int_divider_if.sv
// Request/response bundle between the execute stage and the divider.
interface int_divider_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       div_op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, div_op_i, a_i, b_i, flush_i,
        input  ready_o, busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, div_op_i, a_i, b_i, flush_i,
        output ready_o, busy_o, valid_o, result_o
    );
endinterface

// File: rtl/int_divider_operand_prep.sv
// Combinational operand conditioning: magnitudes, sign flags, special cases.
// INT_DIVIDER_EARLY_OUT_EN enables the |a| < |b| shortcut flag.
module div_operand_prep
    import int_div_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  div_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_mag_o,
    output logic [WIDTH-1:0] b_mag_o,
    output logic             q_sign_o,
    output logic             r_sign_o,
    output logic             div_zero_o,
    output logic             overflow_o,
    output logic             early_out_o
);

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;

    always_comb begin
        case (op_i)
            DIV, REM: is_signed = 1'b1;
            default:  is_signed = 1'b0;
        endcase
        a_neg    = is_signed & a_i[WIDTH-1];
        b_neg    = is_signed & b_i[WIDTH-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = (b_i == '0);
    end

    assign a_mag_o    = a_mag;
    assign b_mag_o    = b_mag;
    assign q_sign_o   = a_neg ^ b_neg;
    assign r_sign_o   = a_neg;
    assign div_zero_o = div_zero;
    assign overflow_o = is_signed && (a_i == INT_MIN) && (b_i == DIV_ZERO_QUOT);

`ifdef INT_DIVIDER_EARLY_OUT_EN
    assign early_out_o = !div_zero && (a_mag < b_mag);
`else
    assign early_out_o = 1'b0;
`endif

endmodule

// File: rtl/int_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one op at a time.
// Optional INT_DIVIDER_EARLY_OUT_EN shortcut lives in div_operand_prep.
module int_divider
    import int_div_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk_i,
    input logic          reset_n_i,
    int_divider_if.slave bus
);

    // state | meaning
    // IDLE  | ready for a request
    // CALC  | WIDTH shift/subtract iterations
    // DONE  | sign fix, result and valid registered on exit
    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_sign_q, q_sign_d;
    logic             r_sign_q, r_sign_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;

    div_op_e          op_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             q_sign, r_sign, div_zero, overflow, early_out;
    logic [WIDTH:0]   shifted, trial;

    assign op_in = div_op_e'(bus.div_op_i);

    div_operand_prep #(.WIDTH(WIDTH)) u_prep (
        .op_i        (op_in),
        .a_i         (bus.a_i),
        .b_i         (bus.b_i),
        .a_mag_o     (a_mag),
        .b_mag_o     (b_mag),
        .q_sign_o    (q_sign),
        .r_sign_o    (r_sign),
        .div_zero_o  (div_zero),
        .overflow_o  (overflow),
        .early_out_o (early_out)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        q_sign_d  = q_sign_q;
        r_sign_d  = r_sign_q;
        valid_d   = 1'b0;
        result_d  = result_q;

        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_q};

        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    op_d      = op_in;
                    divisor_d = b_mag;
                    q_sign_d  = 1'b0;
                    r_sign_d  = 1'b0;
                    state_d   = DONE;
                    // Special cases preload final values; sign fix is bypassed.
                    if (div_zero) begin
                        quot_d = DIV_ZERO_QUOT;
                        rem_d  = bus.a_i;
                    end else if (overflow) begin
                        quot_d = INT_MIN;
                        rem_d  = '0;
                    end else if (early_out) begin
                        quot_d = '0;
                        rem_d  = bus.a_i;
                    end else begin
                        quot_d   = a_mag;
                        rem_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        q_sign_d = q_sign;
                        r_sign_d = r_sign;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = shifted[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                case (op_q)
                    DIV, DIVU: result_d = q_sign_q ? -quot_q : quot_q;
                    default:   result_d = r_sign_q ? -rem_q : rem_q;
                endcase
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush aborts without touching the last visible result.
        if (bus.flush_i && state_q != IDLE) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            q_sign_q  <= 1'b0;
            r_sign_q  <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            q_sign_q  <= q_sign_d;
            r_sign_q  <= r_sign_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.busy_o   = (state_q == CALC) || (state_q == DONE);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider: directed vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_int_divider;

`ifdef INT_DIVIDER_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] exp_hold = 32'h0;

    int_divider_if #(.WIDTH(32)) bus();

    int_divider dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_sgn;
        bit is_rem;
        int sa;
        int sb;
        is_sgn = (op == 2'd0) || (op == 2'd2);
        is_rem = (op == 2'd2) || (op == 2'd3);
        sa = a;
        sb = b;
        if (b == 32'h0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
        if (is_sgn) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_sgn;
        logic [31:0] ma;
        logic [31:0] mb;
        is_sgn = (op == 2'd0) || (op == 2'd2);
        if (b == 32'h0) return 1;
        if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = (is_sgn && a[31]) ? -a : a;
        mb = (is_sgn && b[31]) ? -b : b;
        if (ma < mb) return EARLY_LAT;
        return FULL_LAT;
    endfunction

    // Called in the phase just after a clock edge; returns there too.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        bit seen;
        bus.start_i  = 1'b1;
        bus.div_op_i = op;
        bus.a_i      = a;
        bus.b_i      = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.valid_o) seen = 1'b1;
        end
        check({name, " valid_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " result"}, bus.result_o, exp_r);
            check({name, " latency"}, 32'(lat), 32'(exp_lat));
            exp_hold = exp_r;
            @(posedge clk);
            #1;
            check({name, " valid_pulse"}, 32'(bus.valid_o), 32'd0);
        end
    endtask

    task automatic expect_no_valid(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) seen = 1'b1;
        end
        check({name, " no_valid"}, 32'(seen), 32'd0);
        check({name, " result_held"}, bus.result_o, exp_hold);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{2'd1, 32'd100,        32'd7,        32'd14,        FULL_LAT};
        vecs[1]  = '{2'd3, 32'd100,        32'd7,        32'd2,         FULL_LAT};
        vecs[2]  = '{2'd0, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, FULL_LAT};
        vecs[3]  = '{2'd2, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE, FULL_LAT};
        vecs[4]  = '{2'd0, 32'd5,          32'd0,        32'hFFFF_FFFF, 1};
        vecs[5]  = '{2'd2, 32'd5,          32'd0,        32'd5,         1};
        vecs[6]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        1};
        vecs[8]  = '{2'd1, 32'd3,          32'd10,       32'd0,         EARLY_LAT};
        vecs[9]  = '{2'd3, 32'd3,          32'd10,       32'd3,         EARLY_LAT};
        vecs[10] = '{2'd1, 32'd5,          32'd0,        32'hFFFF_FFFF, 1};
        vecs[11] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        EARLY_LAT};
        vecs[12] = '{2'd2, 32'd7,          32'hFFFF_FFFF, 32'h0,        FULL_LAT};
        vecs[13] = '{2'd0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL_LAT};

        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.div_op_i = 2'd0;
        bus.a_i      = 32'h0;
        bus.b_i      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.ready_o), 32'd1);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset valid", 32'(bus.valid_o), 32'd0);
        check("reset result", bus.result_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Flush during CALC at cycle 10.
        bus.start_i = 1'b1; bus.div_op_i = 2'd1; bus.a_i = 32'd100; bus.b_i = 32'd7;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush busy_before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush ready", 32'(bus.ready_o), 32'd1);
        check("flush busy", 32'(bus.busy_o), 32'd0);
        expect_no_valid("flush_calc", 40);

        // Flush while in DONE of a special-case op.
        bus.start_i = 1'b1; bus.div_op_i = 2'd0; bus.a_i = 32'd5; bus.b_i = 32'd0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_done ready", 32'(bus.ready_o), 32'd1);
        expect_no_valid("flush_done", 5);

        // Flush together with start in IDLE drops the request.
        bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.div_op_i = 2'd0; bus.a_i = 32'd9; bus.b_i = 32'd0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        check("idle_flush busy", 32'(bus.busy_o), 32'd0);
        expect_no_valid("idle_flush", 5);

        // A start pulse mid-operation must be ignored.
        bus.start_i = 1'b1; bus.div_op_i = 2'd1; bus.a_i = 32'd100; bus.b_i = 32'd7;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            if (lat == 4) begin
                check("ignore busy", 32'(bus.busy_o), 32'd1);
                check("ignore ready", 32'(bus.ready_o), 32'd0);
                bus.start_i = 1'b1; bus.div_op_i = 2'd0; bus.a_i = 32'd5; bus.b_i = 32'd0;
            end else begin
                bus.start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (bus.valid_o) seen = 1'b1;
        end
        bus.start_i = 1'b0;
        check("ignore valid_seen", 32'(seen), 32'd1);
        check("ignore result", bus.result_o, 32'd14);
        check("ignore latency", 32'(lat), 32'(FULL_LAT));
        exp_hold = 32'd14;
        @(posedge clk);
        #1;

        // Reset mid-CALC clears everything immediately.
        bus.start_i = 1'b1; bus.div_op_i = 2'd1; bus.a_i = 32'd1000; bus.b_i = 32'd3;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst ready", 32'(bus.ready_o), 32'd1);
        check("midrst busy", 32'(bus.busy_o), 32'd0);
        check("midrst valid", 32'(bus.valid_o), 32'd0);
        check("midrst result", bus.result_o, 32'h0);
        exp_hold = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_no_valid("post_reset", 40);
        run_op("post_reset_op", 2'd1, 32'd100, 32'd7, 32'd14, FULL_LAT);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = $urandom;
                3:       b = 32'hFFFF_FFFF;
                default: b = a >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rnd%0d op%0d a=%08h b=%08h", i, op, a, b), op, a, b,
                   ref_result(op, a, b), ref_latency(op, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
